// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared width constant and FSM state encoding for the
//               instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  // Instruction, data and address width.
  localparam int N = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundle of the fetch unit's program-counter, instruction-memory,
//               decode and redirect signals.
//   master : fetch unit side (drives pc_e/pc_l/pc_d, mem_rd/mem_addr, ir/ir_valid)
//   slave  : environment side (drives run, pc_q, mem_data, ir_ready,
//            br_valid, br_target)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int N = fetch_unit_pkg::N
);

  logic         run;        // fetch enable
  logic [N-1:0] pc_q;       // current program counter
  logic         pc_e;       // program counter increment enable
  logic         pc_l;       // program counter load enable
  logic [N-1:0] pc_d;       // program counter load value
  logic         mem_rd;     // instruction memory read strobe
  logic [N-1:0] mem_addr;   // instruction memory address
  logic [N-1:0] mem_data;   // read data, one cycle after mem_rd
  logic [N-1:0] ir;         // instruction register
  logic         ir_valid;   // ir holds an instruction for decode
  logic         ir_ready;   // decode accepts ir this cycle
  logic         br_valid;   // redirect request
  logic [N-1:0] br_target;  // redirect address

  modport master (
    input  run, pc_q, mem_data, ir_ready, br_valid, br_target,
    output pc_e, pc_l, pc_d, mem_rd, mem_addr, ir, ir_valid
  );

  modport slave (
    output run, pc_q, mem_data, ir_ready, br_valid, br_target,
    input  pc_e, pc_l, pc_d, mem_rd, mem_addr, ir, ir_valid
  );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Four-state instruction fetch sequencer. Issues a read at the
//               program counter, captures the returned word into ir and holds
//               it until decode accepts it. A redirect in any state loads the
//               program counter and squashes any held or in-flight instruction.
// Ports       : clock - sole clock, rising edge
//               reset - asynchronous active-high reset
//               bus   - fetch_unit_if.master (PC, memory, decode, redirect)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int N = fetch_unit_pkg::N
) (
  input  logic           clock,
  input  logic           reset,
  fetch_unit_if.master   bus
);

  state_t       r_state;
  state_t       w_state_next;
  logic [N-1:0] r_ir;
  logic [N-1:0] w_ir_next;
  logic         r_ir_valid;
  logic         w_ir_valid_next;

  logic         w_pc_e;
  logic         w_pc_l;
  logic         w_mem_rd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ir       <= w_ir_next;
      r_ir_valid <= w_ir_valid_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_ir_next       = r_ir;
    w_ir_valid_next = r_ir_valid;
    w_pc_e          = 1'b0;
    w_pc_l          = 1'b0;
    w_mem_rd        = 1'b0;

    // Strobes are combinational from inputs, so they are explicitly held low
    // while reset is asserted (br_valid would otherwise leak onto pc_l).
    if (!reset) begin
      if (bus.br_valid) begin
        // Redirect wins over everything: the held or in-flight instruction is
        // dropped and ir itself is left untouched.
        w_pc_l          = 1'b1;
        w_ir_valid_next = 1'b0;
        w_state_next    = bus.run ? ST_FETCH : ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (bus.run) w_state_next = ST_FETCH;
          end
          ST_FETCH: begin
            // The PC advances on the same edge that issues the read, so the
            // next fetch naturally uses the following address.
            w_mem_rd     = 1'b1;
            w_pc_e       = 1'b1;
            w_state_next = ST_WAIT;
          end
          ST_WAIT: begin
            w_ir_next       = bus.mem_data;
            w_ir_valid_next = 1'b1;
            w_state_next    = ST_HOLD;
          end
          ST_HOLD: begin
            if (bus.ir_ready) begin
              w_ir_valid_next = 1'b0;
              w_state_next    = bus.run ? ST_FETCH : ST_IDLE;
            end
          end
          default: w_state_next = ST_IDLE;
        endcase
      end
    end
  end

  assign bus.pc_e     = w_pc_e;
  assign bus.pc_l     = w_pc_l;
  assign bus.pc_d     = bus.br_target;
  assign bus.mem_rd   = w_mem_rd;
  assign bus.mem_addr = bus.pc_q;
  assign bus.ir       = r_ir;
  assign bus.ir_valid = r_ir_valid;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. Directed stimulus pushes
//               expected fetch / redirect / accept events into a queue; a
//               monitor pops and compares them as the DUT produces them.
//               A program-counter and memory model close the loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int N       = 9;
  localparam int K_FETCH = 0;
  localparam int K_REDIR = 1;
  localparam int K_ACC   = 2;

  typedef struct {
    int           kind;
    logic [N-1:0] value;
  } ev_t;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  ev_t  exp_q[$];

  fetch_unit_if #(.N(N)) bus ();

  fetch_unit #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents: word at address a is a ^ 0x1A5 (so address 0 holds 0x1A5).
  function automatic logic [N-1:0] mem_f(input logic [N-1:0] a);
    return a ^ 9'h1A5;
  endfunction

  // Program counter model.
  always @(posedge clock or posedge reset) begin
    if (reset)            bus.pc_q <= '0;
    else if (bus.pc_l)    bus.pc_q <= bus.pc_d;
    else if (bus.pc_e)    bus.pc_q <= bus.pc_q + 9'd1;
  end

  // Instruction memory model: one-cycle read latency.
  always @(posedge clock) begin
    if (bus.mem_rd) bus.mem_data <= mem_f(bus.mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [N-1:0] value);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: samples mid-cycle and matches each observed event to the queue.
  int           m_kind;
  logic [N-1:0] m_value;
  ev_t          m_exp;
  always @(negedge clock) begin
    check("pc_l_pc_e_exclusive", 32'(bus.pc_l & bus.pc_e), 32'd0);
    if (bus.pc_l || bus.mem_rd || (bus.ir_valid && bus.ir_ready)) begin
      if (bus.pc_l) begin
        m_kind  = K_REDIR;
        m_value = bus.pc_d;
      end else if (bus.mem_rd) begin
        m_kind  = K_FETCH;
        m_value = bus.mem_addr;
      end else begin
        m_kind  = K_ACC;
        m_value = bus.ir;
      end
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: got kind %0d value %0h, expected none (t=%0t)",
                 m_kind, m_value, $time);
      end else begin
        m_exp = exp_q.pop_front();
        check("event_kind", 32'(m_kind), 32'(m_exp.kind));
        check("event_value", 32'(m_value), 32'(m_exp.value));
        if (m_kind == K_FETCH) check("fetch_pc_e", 32'(bus.pc_e), 32'd1);
        if (m_kind == K_REDIR) begin
          check("redir_pc_e", 32'(bus.pc_e), 32'd0);
          check("redir_mem_rd", 32'(bus.mem_rd), 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset         = 1'b1;
    bus.run       = 1'b1;
    bus.ir_ready  = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_target = 9'h0AA;
    bus.mem_data  = '0;

    // Reset: registers cleared and strobes low even with run/br_valid high.
    repeat (2) tick();
    check("rst_ir",       32'(bus.ir),       32'h000);
    check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
    check("rst_pc_l",     32'(bus.pc_l),     32'd0);
    check("rst_pc_e",     32'(bus.pc_e),     32'd0);
    check("rst_mem_rd",   32'(bus.mem_rd),   32'd0);
    bus.run      = 1'b0;
    bus.br_valid = 1'b0;
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // First fetch from address 0, held in HOLD while decode stalls.
    push(K_FETCH, 9'h000);
    push(K_ACC,   9'h1A5);
    push(K_FETCH, 9'h001);
    bus.run = 1'b1;
    tick();
    check("lat_fetch_mem_rd", 32'(bus.mem_rd), 32'd1);
    check("lat_fetch_valid",  32'(bus.ir_valid), 32'd0);
    tick();
    check("lat_wait_valid",   32'(bus.ir_valid), 32'd0);
    tick();
    check("lat_hold_valid",   32'(bus.ir_valid), 32'd1);
    check("lat_hold_ir",      32'(bus.ir),       32'h1A5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_ir",       32'(bus.ir),       32'h1A5);
      check("stall_ir_valid", 32'(bus.ir_valid), 32'd1);
      check("stall_mem_rd",   32'(bus.mem_rd),   32'd0);
      check("stall_pc_e",     32'(bus.pc_e),     32'd0);
    end
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0;
    check("accept_clears_valid", 32'(bus.ir_valid), 32'd0);
    check("accept_next_fetch",   32'(bus.mem_rd),   32'd1);

    // Redirect while the read for address 1 is in flight.
    tick();
    push(K_REDIR, 9'h0F0);
    push(K_FETCH, 9'h0F0);
    bus.br_valid  = 1'b1;
    bus.br_target = 9'h0F0;
    #1;
    check("wait_redir_pc_l", 32'(bus.pc_l), 32'd1);
    check("wait_redir_pc_d", 32'(bus.pc_d), 32'h0F0);
    check("wait_redir_pc_e", 32'(bus.pc_e), 32'd0);
    tick();
    bus.br_valid = 1'b0;
    check("wait_redir_ir_kept",  32'(bus.ir),       32'h1A5);
    check("wait_redir_no_valid", 32'(bus.ir_valid), 32'd0);
    check("wait_redir_addr",     32'(bus.mem_addr), 32'h0F0);
    repeat (2) tick();
    check("target_ir_valid", 32'(bus.ir_valid), 32'd1);
    check("target_ir",       32'(bus.ir),       32'h155);

    // Redirect and accept together in HOLD: held word is squashed.
    push(K_REDIR, 9'h1FF);
    push(K_FETCH, 9'h1FF);
    push(K_ACC,   9'h05A);
    push(K_FETCH, 9'h000);
    push(K_ACC,   9'h1A5);
    push(K_FETCH, 9'h001);
    push(K_ACC,   9'h1A4);
    bus.br_valid  = 1'b1;
    bus.br_target = 9'h1FF;
    bus.ir_ready  = 1'b1;
    tick();
    bus.br_valid = 1'b0;
    check("hold_redir_valid", 32'(bus.ir_valid), 32'd0);
    check("hold_redir_addr",  32'(bus.mem_addr), 32'h1FF);

    // Streaming with ir_ready high: one fetch every three cycles, PC wraps.
    repeat (3) tick();
    check("wrap_mem_rd",   32'(bus.mem_rd),   32'd1);
    check("wrap_mem_addr", 32'(bus.mem_addr), 32'h000);
    repeat (3) tick();
    check("stream_mem_rd",   32'(bus.mem_rd),   32'd1);
    check("stream_mem_addr", 32'(bus.mem_addr), 32'h001);
    // run drops during FETCH: the issued read still completes.
    bus.run = 1'b0;
    repeat (2) tick();
    check("runlow_hold_valid", 32'(bus.ir_valid), 32'd1);
    tick();
    check("runlow_idle_valid", 32'(bus.ir_valid), 32'd0);
    repeat (4) tick();
    check("runlow_no_fetch", 32'(bus.mem_rd), 32'd0);

    // Asynchronous reset in WAIT.
    bus.ir_ready = 1'b0;
    bus.run      = 1'b1;
    push(K_FETCH, 9'h002);
    tick();
    tick();
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_ir",       32'(bus.ir),       32'h000);
    check("async_rst_ir_valid", 32'(bus.ir_valid), 32'd0);
    check("async_rst_mem_rd",   32'(bus.mem_rd),   32'd0);
    bus.run = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst_no_fetch", 32'(bus.mem_rd), 32'd0);

    // Restart after reset.
    push(K_FETCH, 9'h000);
    push(K_ACC,   9'h1A5);
    bus.run      = 1'b1;
    bus.ir_ready = 1'b1;
    tick();
    bus.run = 1'b0;
    repeat (2) tick();
    check("restart_valid", 32'(bus.ir_valid), 32'd1);
    check("restart_ir",    32'(bus.ir),       32'h1A5);
    tick();
    check("restart_idle", 32'(bus.mem_rd), 32'd0);
    repeat (2) tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: N, default 9, instruction, data and address width.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 run  in  1  fetch enable; leaves IDLE when high.
REQ-005 pc_q  in  N  current program-counter value.
REQ-006 pc_e  out  1  program-counter increment enable.
REQ-007 pc_l  out  1  program-counter load enable.
REQ-008 pc_d  out  N  program-counter load value (branch target).
REQ-009 mem_rd  out  1  instruction-memory read strobe.
REQ-010 mem_addr  out  N  instruction-memory address.
REQ-011 mem_data  in  N  read data, valid exactly one cycle after mem_rd.
REQ-012 ir  out  N  instruction register.
REQ-013 ir_valid  out  1  ir holds an instruction for decode.
REQ-014 ir_ready  in  1  decode accepts ir this cycle.
REQ-015 br_valid  in  1  redirect request from execute.
REQ-016 br_target  in  N  redirect address.

Function
REQ-017 FSM states: IDLE, FETCH, WAIT, HOLD; state, ir and ir_valid registered; pc_e, pc_l, pc_d, mem_rd and mem_addr decoded combinationally from state and inputs.
REQ-018 IDLE: all strobes low; run=1 -> FETCH; else stay.
REQ-019 FETCH: mem_rd=1, mem_addr=pc_q, pc_e=1 (PC advances at same edge); next WAIT.
REQ-020 WAIT: ir <= mem_data, ir_valid <= 1; next HOLD.
REQ-021 HOLD: ir_valid=1, ir stable; ir_ready=1 -> ir_valid <= 0 and next FETCH if run=1, else IDLE; ir_ready=0 -> stay.
REQ-022 Throughput: one instruction per 3 cycles with ir_ready held high; first ir_valid 3 cycles after run rises from IDLE.
REQ-023 Redirect: br_valid=1 in any state -> pc_l=1, pc_d=br_target, pc_e=0, mem_rd=0, ir_valid <= 0, next FETCH if run=1 else IDLE.
REQ-024 Redirect priority: br_valid overrides ir_ready and run-state transitions; a held instruction is discarded even if ir_ready=1 that cycle (decode squashes it).
REQ-025 Redirect in WAIT: in-flight mem_data is dropped, ir unchanged.
REQ-026 run falling in FETCH does not abort the issued read; run is sampled only in IDLE and at HOLD exit.
REQ-027 pc_l and pc_e never asserted together.
REQ-028 Address wrap: fetch unit passes pc_q unmodified; wrap from 2^N-1 to 0 is the program counter's behaviour.
REQ-029 ir_valid low whenever state is not HOLD.

Reset
REQ-030 reset asserted -> state IDLE, ir=0, ir_valid=0 immediately, independent of clock.
REQ-031 During reset all strobes (pc_e, pc_l, mem_rd) low; pc_d and mem_addr don't-care.
REQ-032 Reset mid-operation discards any in-flight read; after release, FETCH only once run=1.

Structure
REQ-033 Shared package: width constant N=9 and FSM state enumeration (2-bit encoding).
REQ-034 Single module, no sub-modules; ir register and FSM in one file.

Verification
REQ-035 Reset, run=1, pc_q=0x000, mem_data=0x1A5 -> mem_rd cycle 1 at addr 0x000, pc_e=1 same cycle, ir=0x1A5 with ir_valid at cycle 3.
REQ-036 ir_ready=0 for 4 cycles in HOLD -> ir stable 0x1A5, no mem_rd, no pc_e; ir_ready=1 -> ir_valid low next cycle, FETCH follows.
REQ-037 br_valid=1, br_target=0x0F0 in WAIT -> pc_l=1, pc_d=0x0F0, pc_e=0, mem_data discarded, next fetch at addr 0x0F0.
REQ-038 br_valid=1 and ir_ready=1 together in HOLD -> ir_valid cleared, pc_l=1, pc_e=0, next fetch at br_target.
REQ-039 pc_q=0x1FF fetch -> mem_addr=0x1FF; following fetch at 0x000.
REQ-040 reset asserted mid-WAIT without clock edge -> ir=0, ir_valid=0, state IDLE immediately; no fetch until run=1.
